// File: rtl/sipo_frame_receiver.sv
// -----------------------------------------------------------------------------
// sipo_frame_receiver
//
// Serial-in / parallel-out frame receiver. Serial bits arrive LSB first,
// qualified by bit_en; a bit strobed together with sync starts a new frame.
// Once WIDTH data bits have been gathered, the word is placed in a single
// entry output buffer with a valid/ready handshake. A word that completes
// while the buffer is still held by the consumer is dropped and reported
// with a one-cycle overrun pulse.
//
// Build option:
//   SIPO_PARITY_CHECK_EN  - when defined, each frame carries one extra
//                           even-parity bit after the data bits, and
//                           parity_err reports the check result for the
//                           buffered word. When undefined, frames are
//                           WIDTH bits long and parity_err is tied low.
//
// Parameters:
//   WIDTH       data bits per frame (>= 2)
//
// Ports:
//   clk         clock, rising edge active
//   rst_b       asynchronous reset, active low
//   bit_en      serial strobe; inb/sync are sampled only when high
//   inb         serial data bit, LSB first
//   sync        frame start, qualified by bit_en
//   out_ready   consumer accepts out_data this cycle
//   out_valid   output buffer holds a complete word
//   out_data    received word, bit 0 = first serial bit
//   parity_err  parity status of the buffered word
//   overrun     one-cycle pulse when a completed word is dropped
//   busy        a frame is partially received
// -----------------------------------------------------------------------------
module sipo_frame_receiver #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             bit_en,
    input  logic             inb,
    input  logic             sync,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             parity_err,
    output logic             overrun,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

`ifdef SIPO_PARITY_CHECK_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t           state, next_state;
    logic [CW-1:0]    bit_count, next_count;
    logic [WIDTH-1:0] shift_reg, next_shift;

    // Completion strobe and the finished word, valid in the cycle whose
    // rising edge samples the final bit of a frame.
    logic             word_done;
    logic [WIDTH-1:0] word_data;
`ifdef SIPO_PARITY_CHECK_EN
    logic             word_perr;
`endif

    logic             load;

    // -------------------------------------------------------------------------
    // Receive FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= IDLE;
            bit_count <= '0;
            shift_reg <= '0;
        end else begin
            state     <= next_state;
            bit_count <= next_count;
            shift_reg <= next_shift;
        end
    end

    // -------------------------------------------------------------------------
    // Receive FSM: next state, count and shift datapath
    // -------------------------------------------------------------------------
    // Bits shift in at the MSB and move right, so the first bit of a frame
    // arrives at bit 0 after WIDTH strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        next_state = state;
        next_count = bit_count;
        next_shift = shift_reg;
        word_done  = 1'b0;
        word_data  = shift_reg;
`ifdef SIPO_PARITY_CHECK_EN
        word_perr  = 1'b0;
`endif

        if (bit_en) begin
            if (sync) begin
                // Start (or restart) a frame from any state; a partial frame
                // is simply discarded.
                next_state = SHIFT;
                next_count = CW'(1);
                next_shift = {inb, {(WIDTH-1){1'b0}}};
            end else begin
                case (state)
                    IDLE: begin
                        // Strobes without sync are ignored while idle.
                    end

                    SHIFT: begin
                        next_shift = {inb, shift_reg[WIDTH-1:1]};
                        if (bit_count == LAST_IDX) begin
`ifdef SIPO_PARITY_CHECK_EN
                            next_state = PARITY;
                            next_count = CW'(WIDTH);
`else
                            next_state = IDLE;
                            next_count = '0;
                            word_done  = 1'b1;
                            word_data  = {inb, shift_reg[WIDTH-1:1]};
`endif
                        end else begin
                            next_count = bit_count + 1'b1;
                        end
                    end

`ifdef SIPO_PARITY_CHECK_EN
                    PARITY: begin
                        // Even parity: XOR over data and parity bit is 0
                        // for a good frame.
                        next_state = IDLE;
                        next_count = '0;
                        word_done  = 1'b1;
                        word_data  = shift_reg;
                        word_perr  = ^{shift_reg, inb};
                    end
`endif

                    default: begin
                        next_state = IDLE;
                        next_count = '0;
                    end
                endcase
            end
        end
    end

    assign busy = (state != IDLE);

    // -------------------------------------------------------------------------
    // Output buffer
    // -------------------------------------------------------------------------
    // A completed word is accepted when the buffer is empty or is being
    // emptied on the same edge; otherwise it is dropped.
    assign load = word_done && (!out_valid || out_ready);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            overrun   <= 1'b0;
        end else begin
            overrun <= word_done && out_valid && !out_ready;
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= word_data;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef SIPO_PARITY_CHECK_EN
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            parity_err <= 1'b0;
        end else if (load) begin
            parity_err <= word_perr;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_frame_receiver.sv
// -----------------------------------------------------------------------------
// tb_sipo_frame_receiver
//
// Directed self-checking bench for sipo_frame_receiver with WIDTH = 8.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// The parity section is compiled only with SIPO_PARITY_CHECK_EN defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_sipo_frame_receiver;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_b;
    logic             bit_en;
    logic             inb;
    logic             sync;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             parity_err;
    logic             overrun;
    logic             busy;

    int checks = 0;
    int errors = 0;

    sipo_frame_receiver #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .bit_en     (bit_en),
        .inb        (inb),
        .sync       (sync),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .parity_err (parity_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobe one serial bit through one rising edge.
    task automatic send_bit(input logic b, input logic s);
        bit_en = 1'b1;
        inb    = b;
        sync   = s;
        tick();
        bit_en = 1'b0;
        sync   = 1'b0;
        inb    = 1'b0;
    endtask

    // Full data frame on consecutive cycles, LSB first, sync on bit 0.
    task automatic send_frame(input logic [7:0] d);
        for (int i = 0; i < WIDTH; i++) begin
            send_bit(d[i], i == 0);
        end
    endtask

    initial begin
        logic [7:0] v;

        rst_b     = 1'b0;
        bit_en    = 1'b0;
        inb       = 1'b0;
        sync      = 1'b0;
        out_ready = 1'b0;

        // ---------------- reset state ----------------
        #1;
        check("rst_valid",  out_valid,  0);
        check("rst_data",   out_data,   0);
        check("rst_busy",   busy,       0);
        check("rst_ovr",    overrun,    0);
        check("rst_perr",   parity_err, 0);
        tick();
        tick();
        rst_b = 1'b1;
        tick();

        // strobes without sync are ignored while idle
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        check("idle_nosync_busy", busy, 0);

        // ---------------- basic frame 0xA5 ----------------
        out_ready = 1'b1;
        send_bit(1'b1, 1'b1);
        check("a5_busy_mid", busy, 1);
        for (int i = 1; i < WIDTH; i++) begin
            v = 8'hA5;
            send_bit(v[i], 1'b0);
        end
        check("a5_valid", out_valid,  1);
        check("a5_data",  out_data,   8'hA5);
        check("a5_busy",  busy,       0);
        check("a5_perr",  parity_err, 0);
        tick();
        check("a5_valid_drop", out_valid, 0);

        // ---------------- overrun: 0x3C held, 0xFF dropped ----------------
        out_ready = 1'b0;
        send_frame(8'h3C);
        check("3c_valid", out_valid, 1);
        check("3c_data",  out_data,  8'h3C);
        check("3c_ovr0",  overrun,   0);
        send_frame(8'hFF);
        check("ff_ovr_pulse", overrun,   1);
        check("ff_data_kept", out_data,  8'h3C);
        check("ff_valid",     out_valid, 1);
        tick();
        check("ff_ovr_once",  overrun,   0);
        check("ff_data_stbl", out_data,  8'h3C);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("3c_drained", out_valid, 0);

        // ---------------- 0x81 with gaps between strobes ----------------
        v = 8'h81;
        for (int i = 0; i < WIDTH; i++) begin
            send_bit(v[i], i == 0);
            if (i < WIDTH - 1) begin
                check("81_busy_bit", busy, 1);
                tick();
                check("81_busy_gap", busy, 1);
                check("81_no_valid", out_valid, 0);
            end
        end
        check("81_valid", out_valid, 1);
        check("81_data",  out_data,  8'h81);
        check("81_busy",  busy,      0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("81_drained", out_valid, 0);

        // ---------------- restart mid-frame with 0x5A ----------------
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        check("restart_no_valid", out_valid, 0);
        send_frame(8'h5A);
        check("5a_valid", out_valid, 1);
        check("5a_data",  out_data,  8'h5A);
        check("5a_ovr",   overrun,   0);
        tick();
        check("5a_ovr_after", overrun, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("5a_drained", out_valid, 0);

        // ---------------- completion coinciding with transfer ----------------
        send_frame(8'h12);
        check("12_data", out_data, 8'h12);
        v = 8'h34;
        for (int i = 0; i < WIDTH - 1; i++) begin
            send_bit(v[i], i == 0);
        end
        check("34_hold_data", out_data, 8'h12);
        out_ready = 1'b1;
        send_bit(v[WIDTH-1], 1'b0);
        check("34_valid", out_valid, 1);
        check("34_data",  out_data,  8'h34);
        check("34_ovr",   overrun,   0);
        tick();
        out_ready = 1'b0;
        check("34_drained", out_valid, 0);

        // ---------------- reset mid-frame with a buffered word ----------------
        send_frame(8'h99);
        check("99_valid", out_valid, 1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        check("pre_rst_busy", busy, 1);
        rst_b = 1'b0;
        #1;
        check("mid_rst_valid", out_valid,  0);
        check("mid_rst_data",  out_data,   0);
        check("mid_rst_busy",  busy,       0);
        check("mid_rst_ovr",   overrun,    0);
        check("mid_rst_perr",  parity_err, 0);
        tick();
        rst_b = 1'b1;
        tick();
        // remaining bits of the old frame must not be taken up
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        check("post_rst_busy",  busy,      0);
        check("post_rst_valid", out_valid, 0);
        send_frame(8'h0F);
        check("0f_valid", out_valid, 1);
        check("0f_data",  out_data,  8'h0F);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("0f_drained", out_valid, 0);

`ifdef SIPO_PARITY_CHECK_EN
        // ---------------- parity frames ----------------
        send_frame(8'h07);
        check("p1_wait_valid", out_valid, 0);
        check("p1_wait_busy",  busy,      1);
        send_bit(1'b1, 1'b0);
        check("p1_valid", out_valid,  1);
        check("p1_data",  out_data,   8'h07);
        check("p1_perr",  parity_err, 0);
        check("p1_busy",  busy,       0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        send_frame(8'h07);
        send_bit(1'b0, 1'b0);
        check("p0_valid", out_valid,  1);
        check("p0_data",  out_data,   8'h07);
        check("p0_perr",  parity_err, 1);
        tick();
        check("p0_perr_stable", parity_err, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sipo_frame_receiver.md
SIPO_FRAME_RECEIVER -- requirements
Module: sipo_frame_receiver

Interface
REQ-001 Parameter: WIDTH, default 32, data bits per frame; legal range WIDTH >= 2.
REQ-002 clk  in  1  clock; all state changes on rising edge.
REQ-003 rst_b  in  1  reset, asynchronous, active-low.
REQ-004 bit_en  in  1  serial strobe; inb is sampled only in cycles with bit_en=1.
REQ-005 inb  in  1  serial data bit, LSB first.
REQ-006 sync  in  1  frame start; meaningful only with bit_en=1; the inb sampled with it is data bit 0.
REQ-007 out_ready  in  1  consumer accepts out_data this cycle.
REQ-008 out_valid  out  1  output buffer holds a complete word.
REQ-009 out_data  out  WIDTH  received word, bit 0 = first serial bit.
REQ-010 parity_err  out  1  parity status of the buffered word; constant 0 when parity is compiled out.
REQ-011 overrun  out  1  one-cycle pulse when a completed word is dropped.
REQ-012 busy  out  1  high while a frame is partially received (SHIFT or PARITY state).

Function
REQ-013 FSM states SHALL be IDLE, SHIFT and PARITY; PARITY exists only with REQ-029.
REQ-014 IDLE: bit_en=1 and sync=1 SHALL load inb as bit 0, set bit count to 1 and go to SHIFT; bit_en=1 with sync=0 SHALL be ignored.
REQ-015 SHIFT: bit_en=1 and sync=0 SHALL shift right, with inb entering bit WIDTH-1, and increment the count; bit_en=0 SHALL hold all state.
REQ-016 The data bit that brings the count to WIDTH SHALL complete the frame; the FSM then goes to IDLE, or to PARITY with REQ-029.
REQ-017 bit_en=1 and sync=1 in SHIFT or PARITY SHALL discard the partial frame and restart it as in REQ-014; overrun SHALL NOT pulse.
REQ-018 Bit count width SHALL be clog2(WIDTH+1); count SHALL never exceed WIDTH.
REQ-019 A completed word SHALL be written to the output buffer on the rising edge that samples its final bit; out_valid SHALL be visible from the following cycle.
REQ-020 Transfer occurs when out_valid=1 and out_ready=1; out_valid SHALL then fall the next cycle unless a new word is written on that same edge.
REQ-021 When a word completes in the same cycle as a transfer, the new word SHALL load and out_valid SHALL stay 1.
REQ-022 When a word completes while out_valid=1 and out_ready=0, the new word SHALL be dropped, the buffer left unchanged and overrun pulsed for exactly one cycle.
REQ-023 out_data and parity_err SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 busy SHALL equal (state != IDLE).

Reset
REQ-025 rst_b=0 SHALL immediately force: state IDLE, bit count 0, shift register 0, out_valid=0, out_data=0, parity_err=0, overrun=0, busy=0.
REQ-026 A reset mid-frame SHALL discard the partial frame; after reset the block SHALL wait for a new sync.
REQ-027 A buffered, unconsumed word SHALL be lost on reset.

Configuration
REQ-028 Macro SIPO_PARITY_CHECK_EN SHALL select the frame format.
REQ-029 Defined: after WIDTH data bits, the next strobed bit (bit_en=1, sync=0) in PARITY SHALL be the even-parity bit, and that bit completes the frame. parity_err = XOR of all data bits and the parity bit. A word with a parity error is still delivered.
REQ-030 Undefined: no PARITY state; the frame completes on data bit WIDTH-1; parity_err SHALL be tied to 0.

Verification (WIDTH=8)
REQ-031 Send sync + bits 1,0,1,0,0,1,0,1 on consecutive cycles with out_ready=1 -> out_valid=1 for one cycle after the 8th bit, out_data=0xA5, busy=0.
REQ-032 Hold out_ready=0; send frame 0x3C, then frame 0xFF -> out_data stays 0x3C and overrun pulses once at completion of 0xFF; set out_ready=1 for one cycle -> out_valid=0 next cycle.
REQ-033 Send 0x81 with bit_en=1 only on alternate cycles -> out_data=0x81; busy stays high throughout the gaps.
REQ-034 Send 3 bits of any frame, then sync + the bits of 0x5A -> a single word 0x5A and no overrun.
REQ-035 Pulse rst_b low after 4 bits -> all outputs 0 immediately; then a full frame 0x0F -> out_data=0x0F.
REQ-036 With SIPO_PARITY_CHECK_EN defined: send 0x07 + parity bit 1 -> parity_err=0; send 0x07 + parity bit 0 -> parity_err=1 and out_data=0x07.
